// File: rtl/dffe_pipe_pkg.sv
// dffe_pipe_pkg
//   Shared constants and helpers for the dffe_pipe register pipeline.
//   - OVR_MASK / OVR_LOAD : selectors for the OVR_MODE parameter.
//   - occ_width()         : width of the occupancy count for a given depth.
package dffe_pipe_pkg;

  // Override only the output net; the pipeline keeps running underneath.
  localparam int OVR_MASK = 0;
  // Override the last register; the forced value persists after release.
  localparam int OVR_LOAD = 1;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : dffe_pipe_pkg

// File: rtl/dffe_pipe_if.sv
// dffe_pipe_if
//   Bundles the data/control/status signals of dffe_pipe.
//   master : drives en, din, din_vld, flush, ovr_en, ovr_val; observes q, q_vld, occ.
//   slave  : the pipeline side (inputs/outputs mirrored).
interface dffe_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  import dffe_pipe_pkg::*;

  localparam int OCC_W = occ_width(DEPTH);

  logic             en;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic             flush;
  logic             ovr_en;
  logic [WIDTH-1:0] ovr_val;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic [OCC_W-1:0] occ;

  modport master (
    output en, din, din_vld, flush, ovr_en, ovr_val,
    input  q, q_vld, occ
  );

  modport slave (
    input  en, din, din_vld, flush, ovr_en, ovr_val,
    output q, q_vld, occ
  );

endinterface : dffe_pipe_if

// File: rtl/dffe_stage.sv
// dffe_stage
//   One pipeline stage: WIDTH data bits plus a valid bit.
//   Update priority per edge: rst_i > ld_i > flush_i > en_i > hold.
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     en_i              advance: capture d_i / d_vld_i
//     flush_i           clear valid, keep data
//     ld_i, ld_val_i    forced load of ld_val_i with valid=1
//     d_i, d_vld_i      data/valid from the previous stage (or pipeline input)
//     q_o, q_vld_o      registered stage contents
module dffe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             d_vld_i,
  output logic [WIDTH-1:0] q_o,
  output logic             q_vld_o
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  // Next-state selection; a load beats flush and advance.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (ld_i) begin
      data_d = ld_val_i;
      vld_d  = 1'b1;
    end else if (flush_i) begin
      // Flush only invalidates; data is left in place.
      vld_d  = 1'b0;
    end else if (en_i) begin
      data_d = d_i;
      vld_d  = d_vld_i;
    end else begin
      data_d = data_q;
      vld_d  = vld_q;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o     = data_q;
  assign q_vld_o = vld_q;

endmodule : dffe_stage

// File: rtl/dffe_pipe.sv
// dffe_pipe
//   WIDTH-bit, DEPTH-stage register pipeline with clock enable, per-stage
//   valid tracking, flush, occupancy count and a hardware output override.
//   OVR_MODE = OVR_MASK : override replaces the output net only.
//   OVR_MODE = OVR_LOAD : override also loads the last stage every edge.
//   Ports:
//     clk_i  rising-edge clock
//     rst_i  synchronous active-high reset; also gates outputs to reset values
//     bus    dffe_pipe_if slave: en, din, din_vld, flush, ovr_en, ovr_val in;
//            q, q_vld, occ out
module dffe_pipe
  import dffe_pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter int               OVR_MODE = OVR_MASK,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  dffe_pipe_if.slave  bus
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [WIDTH-1:0] stg_data_s [DEPTH];
  logic [DEPTH-1:0] stg_vld_s;
  logic [OCC_W-1:0] occ_cnt_s;
  logic [WIDTH-1:0] q_s;
  logic             q_vld_s;
  logic [OCC_W-1:0] occ_s;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] d_s;
    logic             d_vld_s;
    logic             ld_s;

    if (gi == 0) begin : g_head
      assign d_s     = bus.din;
      assign d_vld_s = bus.din_vld;
    end else begin : g_body
      assign d_s     = stg_data_s[gi-1];
      assign d_vld_s = stg_vld_s[gi-1];
    end

    // Only the output stage can be loaded, and only in load mode.
    if ((OVR_MODE == OVR_LOAD) && (gi == DEPTH - 1)) begin : g_ld
      assign ld_s = bus.ovr_en;
    end else begin : g_no_ld
      assign ld_s = 1'b0;
    end

    dffe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (bus.en),
      .flush_i  (bus.flush),
      .ld_i     (ld_s),
      .ld_val_i (bus.ovr_val),
      .d_i      (d_s),
      .d_vld_i  (d_vld_s),
      .q_o      (stg_data_s[gi]),
      .q_vld_o  (stg_vld_s[gi])
    );
  end

  // Popcount of the registered valid bits.
  always_comb begin
    occ_cnt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt_s = occ_cnt_s + OCC_W'(stg_vld_s[i]);
    end
  end

  // Output mux: reset gating first, then override, then the last stage.
  always_comb begin
    q_s     = stg_data_s[DEPTH-1];
    q_vld_s = stg_vld_s[DEPTH-1];
    occ_s   = occ_cnt_s;
    if (rst_i) begin
      q_s     = RST_VAL;
      q_vld_s = 1'b0;
      occ_s   = '0;
    end else if (bus.ovr_en) begin
      // occ still reflects registered state; a load only counts once stored.
      q_s     = bus.ovr_val;
      q_vld_s = 1'b1;
    end else begin
      q_s     = stg_data_s[DEPTH-1];
      q_vld_s = stg_vld_s[DEPTH-1];
    end
  end

  assign bus.q     = q_s;
  assign bus.q_vld = q_vld_s;
  assign bus.occ   = occ_s;

endmodule : dffe_pipe

// File: doc/dffe_pipe.md
Name: dffe_pipe

Overview:
- Parametrised successor to the single D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with clock enable, per-stage valid tracking, flush and occupancy count.
- Adds a synthesizable output override that reproduces the two force/release semantics in hardware:
  - Mask mode: override the net only; the pipeline keeps running.
  - Load mode: override the register; the forced value is retained after release until the next write.
- Used as a generic delay/retiming element and as a controllable bring-up and debug register.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); latency in enabled cycles.
- OVR_MODE, 0, override semantics: 0 = OVR_MASK, 1 = OVR_LOAD.
- RST_VAL, 0, WIDTH-bit reset value of every stage's data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = all stages hold.
- din  in  WIDTH  input data, sampled into stage 0 when en=1.
- din_vld  in  1  valid tag for din.
- flush  in  1  clears all valid bits (synchronous).
- ovr_en  in  1  override active.
- ovr_val  in  WIDTH  override value.
- q  out  WIDTH  pipeline output.
- q_vld  out  1  output valid.
- occ  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stage state: data s[0..DEPTH-1] and valid v[0..DEPTH-1]; s[DEPTH-1] is the output stage.
- Priority at each rising edge: rst > ovr load (OVR_LOAD, last stage only) > flush > en.
- Reset:
  - rst=1 at an edge sets s[*]=RST_VAL and v[*]=0.
  - While rst=1, q=RST_VAL, q_vld=0 and occ=0, regardless of ovr_en (combinational gating).
- Advance (en=1, no flush):
  - s[0]<=din, v[0]<=din_vld; s[i]<=s[i-1], v[i]<=v[i-1].
  - din sampled at edge k appears on q after edge k+DEPTH-1, i.e. DEPTH enabled edges including the sampling edge.
  - Bubbles (din_vld=0) propagate as v=0; data still shifts.
- Stall (en=0): all s and v hold. q, q_vld and occ stable unless ovr_en changes.
- Flush:
  - flush=1 sets v[*]<=0; data registers are unchanged.
  - flush with en=1 in the same cycle: flush wins, din is not captured, nothing shifts.
- Output with ovr_en=0: q=s[DEPTH-1], q_vld=v[DEPTH-1].
- OVR_MASK (ovr_en=1):
  - q=ovr_val, q_vld=1, combinational in the same cycle.
  - Pipeline state evolves exactly as if ovr_en were 0.
  - On release, q immediately shows the current s[DEPTH-1].
- OVR_LOAD (ovr_en=1):
  - q=ovr_val and q_vld=1 combinationally.
  - Each edge: s[DEPTH-1]<=ovr_val and v[DEPTH-1]<=1, regardless of en and flush.
  - Stages 0..DEPTH-2 follow the normal en/flush rules.
  - On release, q keeps the last loaded ovr_val with q_vld=1 until the next enabled edge shifts s[DEPTH-2] in.
  - Flush and ovr_en in the same cycle: v[0..DEPTH-2]=0, v[DEPTH-1]=1.
- occ:
  - Popcount of v, combinational from registered state.
  - Range 0..DEPTH; no saturation logic is needed.
  - OVR_MASK does not affect occ; OVR_LOAD counts the loaded last stage once it is registered.
- DEPTH=1: stage 0 is the output stage; all rules apply, and OVR_LOAD overwrites the sole stage.
- No X propagation: every register is reset.

Decomposition:
- Package dffe_pipe_pkg holds:
  - localparam OVR_MASK=0 and OVR_LOAD=1.
  - A function computing the occ width, $clog2(DEPTH+1).
- Sub-module dffe_stage: one WIDTH+1-bit stage.
  - Inputs: clk, rst, en, flush, ld, ld_val, d, d_vld.
  - Outputs: q, q_vld.
  - Instantiated DEPTH times via generate; ld is tied to 0 except on the last stage in OVR_LOAD mode.
- Top level contains the generate loop, output mux, rst gating and popcount.

Test Plan:
- All test configurations use WIDTH=8, DEPTH=3 unless noted.
- Reset: rst=1 for 2 cycles with ovr_en=1, ovr_val=0xFF -> q=0x00, q_vld=0, occ=0 throughout.
- Stream: en=1; din 0x11, 0x22, 0x33 with vld=1 on edges 1-3 -> q=0x11 after edge 3, 0x22 after edge 4, 0x33 after edge 5; occ counts 1, 2, 3.
- Stall/bubble: en=0 for 2 cycles after edge 4 -> q=0x22 held, occ=3 held. Then a din_vld=0 bubble -> q_vld=0 exactly 3 enabled edges later, occ drops by 1.
- OVR_MASK: while streaming, ovr_en=1 with ovr_val=0xA5 for 2 cycles -> q=0xA5, q_vld=1 in the same cycles. After release, q equals the unaffected pipeline value, e.g. 0x33.
- OVR_LOAD: same stimulus with en=0 after release -> q stays 0xA5, q_vld=1. The first en=1 edge then gives q=s[1]'s prior value.
- Flush collisions:
  - flush=1 with en=1, din=0x44, vld=1 -> occ=0 next cycle and 0x44 never appears with q_vld=1.
  - OVR_LOAD: flush+ovr_en together -> occ=1, q_vld=1.
  - rst mid-override -> reset values in both modes.
